exp_pwm_dac: RTL and testbench

//   Downstream output stage for the DDS expansion block: takes its 8-bit sample stream and drives a 1-bit PWM pin.
//   An external RC filter recovers the analog waveform.

---
 rtl/exp_pwm_dac_pkg.sv | 33 +++
 rtl/exp_pwm_prescaler.sv | 25 ++
 rtl/exp_pwm_dac.sv | 136 +++++++++++++
 tb/tb_exp_pwm_dac.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pwm_dac_pkg.sv
// Shared constants for the expansion-bus PWM DAC.
// Bus addresses, FSM encoding and CTL bit positions.
package exp_pwm_dac_pkg;

  localparam logic [6:0] EXP_ADDR_CTL  = 7'h7C;
  localparam logic [6:0] EXP_ADDR_PRE  = 7'h7D;
  localparam logic [6:0] EXP_ADDR_RSV0 = 7'h7E;
  localparam logic [6:0] EXP_ADDR_RSV1 = 7'h7F;

  localparam int CTL_EN   = 0;
  localparam int CTL_INV  = 1;
  localparam int CTL_BUSY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  function automatic logic [7:0] ctl_word(
    input logic busy,
    input logic inv,
    input logic en
  );
    logic [7:0] w;
    w = 8'h00;
    w[CTL_BUSY] = busy;
    w[CTL_INV]  = inv;
    w[CTL_EN]   = en;
    return w;
  endfunction

endpackage

// File: rtl/exp_pwm_prescaler.sv
// Tick generator: one tick every P+1 clocks while running.
// A new P is compared immediately against the live count.
module exp_pwm_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_p,
  input  logic       i_run,
  output logic       o_tick
);

  logic [7:0] r_cnt;

  assign o_tick = i_run && (r_cnt >= i_p);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (!i_run || o_tick) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/exp_pwm_dac.sv
// PWM DAC on the PIC expansion bus, double-buffered duty.
// Define PWMDAC_SIGDELTA_EN for a first-order sigma-delta output.
module exp_pwm_dac
  import exp_pwm_dac_pkg::*;
#(
  parameter logic [6:0] ADDR_CTL = EXP_ADDR_CTL,
  parameter logic [6:0] ADDR_PRE = EXP_ADDR_PRE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  output logic [7:0] expdin,
  input  logic [7:0] expdout,
  input  logic [6:0] expaddr,
  input  logic       expread,
  input  logic       expwrite,
  output logic       pwm_out,
  output logic       period_tk
);

  state_t     r_state;
  logic       r_en;
  logic       r_inv;
  logic [7:0] r_pre;
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_duty;
  logic       r_pwm;
  logic       r_tk;

  logic w_run;
  logic w_tick;
  logic w_wrap;
  logic w_raw;
  logic w_wr_ctl;
  logic w_wr_pre;

  assign w_run    = (r_state != ST_IDLE);
  assign w_wrap   = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_wr_ctl = expwrite && (expaddr == ADDR_CTL);
  assign w_wr_pre = expwrite && (expaddr == ADDR_PRE);

  exp_pwm_prescaler u_presc (
    .clk    (clk),
    .reset  (reset),
    .i_p    (r_pre),
    .i_run  (w_run),
    .o_tick (w_tick)
  );

`ifdef PWMDAC_SIGDELTA_EN
  logic [7:0] r_acc;
  logic       r_c;
  logic [8:0] w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_duty};
  assign w_raw = r_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= 8'd0;
      r_c   <= 1'b0;
    end else if (!w_run) begin
      r_acc <= 8'd0;
      r_c   <= 1'b0;
    end else if (w_tick) begin
      r_acc <= w_sum[7:0];
      r_c   <= w_sum[8];
    end
  end
`else
  assign w_raw = (r_pwm_cnt < r_duty);
`endif

  always_comb begin
    expdin = 8'h00;
    if (expread && (expaddr == ADDR_CTL)) begin
      expdin = ctl_word(w_run, r_inv, r_en);
    end else if (expread && (expaddr == ADDR_PRE)) begin
      expdin = r_pre;
    end
  end

  // FSM reads the pre-write EN, so a CTL write on a wrap clock
  // only takes effect after that wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_en      <= 1'b0;
      r_inv     <= 1'b0;
      r_pre     <= 8'd0;
      r_pwm_cnt <= 8'd0;
      r_duty    <= 8'd0;
      r_pwm     <= 1'b0;
      r_tk      <= 1'b0;
    end else begin
      r_pwm <= w_run ? (w_raw ^ r_inv) : r_inv;
      r_tk  <= w_wrap;
      if (w_wr_ctl) begin
        r_en  <= expdout[CTL_EN];
        r_inv <= expdout[CTL_INV];
      end
      if (w_wr_pre) begin
        r_pre <= expdout;
      end
      unique case (r_state)
        ST_IDLE: begin
          r_pwm_cnt <= 8'd0;
          if (r_en) begin
            r_state <= ST_RUN;
            r_duty  <= sample_in;
          end
        end
        ST_RUN, ST_STOP: begin
          if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
          end
          if (w_wrap) begin
            r_duty <= sample_in;
          end
          if (r_state == ST_RUN) begin
            if (!r_en) r_state <= ST_STOP;
          end else if (r_en) begin
            r_state <= ST_RUN;
          end else if (w_wrap) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pwm_out   = r_pwm;
  assign period_tk = r_tk;

endmodule

// File: tb/tb_exp_pwm_dac.sv
// Self-checking bench for exp_pwm_dac against a behavioural model.
// Honours PWMDAC_SIGDELTA_EN for the sigma-delta scenario.
module tb_exp_pwm_dac;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic [7:0] expdin;
  logic [7:0] expdout = 8'h00;
  logic [6:0] expaddr = 7'h7C;
  logic       expread = 1'b1;
  logic       expwrite = 1'b0;
  logic       pwm_out;
  logic       period_tk;

  int checks = 0;
  int errors = 0;

  exp_pwm_dac dut (
    .clk       (clk),
    .reset     (reset),
    .sample_in (sample_in),
    .expdin    (expdin),
    .expdout   (expdout),
    .expaddr   (expaddr),
    .expread   (expread),
    .expwrite  (expwrite),
    .pwm_out   (pwm_out),
    .period_tk (period_tk)
  );

  always #5 clk = ~clk;

  // Behavioural model: prescale count, PWM count, plain arithmetic.
  bit m_run, m_stop, m_en, m_inv, m_pwm, m_tk, m_c;
  int m_pc, m_cnt, m_duty, m_pre, m_acc;

  task automatic m_clear();
    m_pc = 0; m_cnt = 0; m_acc = 0; m_c = 0;
  endtask

  task automatic model_step();
    bit tick, wrap, raw;
    int s;
    if (reset) begin
      m_run = 0; m_stop = 0; m_en = 0; m_inv = 0;
      m_pwm = 0; m_tk = 0; m_duty = 0; m_pre = 0;
      m_clear();
    end else begin
      tick = m_run && (m_pc >= m_pre);
      wrap = tick && (m_cnt == 255);
`ifdef PWMDAC_SIGDELTA_EN
      raw = m_c;
`else
      raw = (m_cnt < m_duty);
`endif
      m_pwm = m_run ? (raw ^ m_inv) : m_inv;
      m_tk = wrap;
      if (!m_run) begin
        m_clear();
        if (m_en) begin
          m_run = 1; m_stop = 0; m_duty = int'(sample_in);
        end
      end else begin
        if (tick) begin
          s = m_acc + m_duty;
          m_c = (s > 255);
          m_acc = s % 256;
          m_cnt = (m_cnt + 1) % 256;
        end
        m_pc = tick ? 0 : m_pc + 1;
        if (wrap) m_duty = int'(sample_in);
        if (m_stop) begin
          if (m_en) m_stop = 0;
          else if (wrap) begin m_run = 0; m_clear(); end
        end else if (!m_en) m_stop = 1;
      end
      if (expwrite && expaddr == 7'h7C) begin
        m_en = expdout[0]; m_inv = expdout[1];
      end
      if (expwrite && expaddr == 7'h7D) m_pre = int'(expdout);
    end
  endtask

  always @(posedge clk or posedge reset) model_step();

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (!expread) return 8'h00;
    if (a == 7'h7C) return {5'b0, m_run, m_inv, m_en};
    if (a == 7'h7D) return 8'(m_pre);
    return 8'h00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    expwrite = 0; expread = 1; expaddr = 7'h7C;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    expaddr = a; expdout = d; expwrite = 1;
    @(negedge clk);
    expwrite = 0; expaddr = 7'h7C;
  endtask

  task automatic test_reset();
    checks++;
    if (pwm_out !== 1'b0 || period_tk !== 1'b0 || expdin !== 8'h00) begin
      errors++;
      $display("FAIL reset_init pwm=%b tk=%b ctl=%h want 0 0 00",
               pwm_out, period_tk, expdin);
    end
    reset = 0;
    sample_in = 8'hFF;
    wr(7'h7D, 8'h00);
    wr(7'h7C, 8'h01);
    repeat (100) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b1 || expdin !== 8'h05) begin
      errors++;
      $display("FAIL reset_prerun pwm=%b ctl=%h want 1 05", pwm_out, expdin);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (pwm_out !== 1'b0 || period_tk !== 1'b0 || expdin !== 8'h00) begin
      errors++;
      $display("FAIL reset_async pwm=%b tk=%b ctl=%h want 0 0 00",
               pwm_out, period_tk, expdin);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if (expdin !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl ctl=%h want 00", expdin);
    end
    expaddr = 7'h7D;
    #1;
    checks++;
    if (expdin !== 8'h00) begin
      errors++;
      $display("FAIL reset_pre pre=%h want 00", expdin);
    end
    expaddr = 7'h7C;
  endtask

  task automatic test_p0();
    int last, hi, nper;
    do_reset();
    sample_in = 8'h40;
    wr(7'h7D, 8'h00);
    wr(7'h7C, 8'h01);
    last = -1; hi = 0; nper = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_tk !== m_tk) begin
        errors++;
        $display("FAIL p0_model cyc=%0d pwm=%b tk=%b want %b %b",
                 i, pwm_out, period_tk, m_pwm, m_tk);
      end
      if (period_tk === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last !== 256) begin
            errors++;
            $display("FAIL p0_period got=%0d want 256", i - last);
          end
          checks++;
          if (hi !== 64) begin
            errors++;
            $display("FAIL p0_high got=%0d want 64", hi);
          end
        end
        nper++; last = i; hi = 0;
      end
      hi += int'(pwm_out);
    end
    checks++;
    if (nper < 3) begin
      errors++;
      $display("FAIL p0_ticks got=%0d want >=3", nper);
    end
  endtask

  task automatic test_p3_change();
    int last, hi, nper;
    int exp_hi[2];
    exp_hi[0] = 256; exp_hi[1] = 768;
    do_reset();
    sample_in = 8'h40;
    wr(7'h7D, 8'h03);
    wr(7'h7C, 8'h01);
    last = -1; hi = 0; nper = 0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_tk !== m_tk) begin
        errors++;
        $display("FAIL p3_model cyc=%0d pwm=%b tk=%b want %b %b",
                 i, pwm_out, period_tk, m_pwm, m_tk);
      end
      if (period_tk === 1'b1) begin
        if (last >= 0 && nper <= 2) begin
          checks++;
          if (i - last !== 1024) begin
            errors++;
            $display("FAIL p3_period got=%0d want 1024", i - last);
          end
          checks++;
          if (hi !== exp_hi[nper-1]) begin
            errors++;
            $display("FAIL p3_high got=%0d want %0d", hi, exp_hi[nper-1]);
          end
        end
        nper++; last = i; hi = 0;
      end
      hi += int'(pwm_out);
      if (nper == 1 && i == last + 300) sample_in = 8'hC0;
    end
    checks++;
    if (nper < 3) begin
      errors++;
      $display("FAIL p3_ticks got=%0d want >=3", nper);
    end
  endtask

  task automatic test_stop();
    int n, last, nper;
    bit done;
    do_reset();
    sample_in = 8'h80;
    wr(7'h7D, 8'h00);
    wr(7'h7C, 8'h01);
    n = 0;
    while (m_cnt != 100 && n < 600) begin @(negedge clk); n++; end
    expaddr = 7'h7C; expdout = 8'h00; expwrite = 1;
    @(negedge clk);
    expwrite = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      checks++;
      if (expdin !== m_read(7'h7C) || pwm_out !== m_pwm) begin
        errors++;
        $display("FAIL stop_model cyc=%0d ctl=%h pwm=%b want %h %b",
                 i, expdin, pwm_out, m_read(7'h7C), m_pwm);
      end
      if (period_tk === 1'b1) begin
        done = 1;
        checks++;
        if (expdin[2] !== 1'b0 || pwm_out !== 1'b0) begin
          errors++;
          $display("FAIL stop_wrap busy=%b pwm=%b want 0 0",
                   expdin[2], pwm_out);
        end
      end else begin
        checks++;
        if (expdin[2] !== 1'b1) begin
          errors++;
          $display("FAIL stop_busy cyc=%0d busy=%b want 1", i, expdin[2]);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL stop_timeout got no wrap want wrap");
    end
    repeat (300) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b0 || period_tk !== 1'b0 || expdin !== 8'h00) begin
        errors++;
        $display("FAIL stop_idle pwm=%b tk=%b ctl=%h want 0 0 00",
                 pwm_out, period_tk, expdin);
      end
    end
    // Re-enable before the wrap: periods must stay contiguous.
    wr(7'h7C, 8'h01);
    n = 0;
    while (m_cnt != 100 && n < 600) begin @(negedge clk); n++; end
    wr(7'h7C, 8'h00);
    n = 0;
    while (m_cnt != 200 && n < 600) begin @(negedge clk); n++; end
    wr(7'h7C, 8'h01);
    last = -1; nper = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_tk !== m_tk || expdin[2] !== 1'b1) begin
        errors++;
        $display("FAIL regap_model cyc=%0d pwm=%b tk=%b busy=%b want %b %b 1",
                 i, pwm_out, period_tk, expdin[2], m_pwm, m_tk);
      end
      if (period_tk === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last !== 256) begin
            errors++;
            $display("FAIL regap_period got=%0d want 256", i - last);
          end
        end
        last = i; nper++;
      end
    end
    checks++;
    if (nper < 2) begin
      errors++;
      $display("FAIL regap_ticks got=%0d want >=2", nper);
    end
  endtask

  task automatic test_inv();
    do_reset();
    sample_in = 8'h00;
    wr(7'h7C, 8'h02);
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b1 || expdin !== 8'h02) begin
        errors++;
        $display("FAIL inv_idle pwm=%b ctl=%h want 1 02", pwm_out, expdin);
      end
    end
    wr(7'h7C, 8'h03);
    repeat (600) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b1 || pwm_out !== m_pwm) begin
        errors++;
        $display("FAIL inv_run pwm=%b want 1", pwm_out);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] addrs[4];
    addrs[0] = 7'h7C; addrs[1] = 7'h7D;
    addrs[2] = 7'h7E; addrs[3] = 7'h15;
    do_reset();
    sample_in = 8'($urandom);
    wr(7'h7C, 8'h01);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_tk !== m_tk) begin
        errors++;
        $display("FAIL rand_model cyc=%0d pwm=%b tk=%b want %b %b",
                 i, pwm_out, period_tk, m_pwm, m_tk);
      end
      expwrite = 0;
      expread = ($urandom_range(0, 7) != 0);
      expaddr = addrs[$urandom_range(0, 3)];
      if ($urandom_range(0, 49) == 0) sample_in = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        expaddr = 7'h7C;
        expdout = 8'($urandom) | 8'($urandom_range(0, 3) != 0);
        expwrite = 1;
      end else if ($urandom_range(0, 399) == 0) begin
        expaddr = 7'h7D;
        expdout = 8'($urandom_range(0, 3));
        expwrite = 1;
      end
      #1;
      checks++;
      if (expdin !== m_read(expaddr)) begin
        errors++;
        $display("FAIL rand_read cyc=%0d addr=%h got=%h want %h",
                 i, expaddr, expdin, m_read(expaddr));
      end
    end
    @(negedge clk);
    expwrite = 0; expread = 1; expaddr = 7'h7C;
  endtask

`ifdef PWMDAC_SIGDELTA_EN
  task automatic test_sigdelta();
    logic prev;
    do_reset();
    sample_in = 8'h80;
    wr(7'h7D, 8'h00);
    wr(7'h7C, 8'h01);
    repeat (4) @(negedge clk);
    prev = pwm_out;
    repeat (200) begin
      @(negedge clk);
      checks++;
      if (pwm_out === prev || pwm_out !== m_pwm) begin
        errors++;
        $display("FAIL sd_toggle pwm=%b prev=%b want toggle", pwm_out, prev);
      end
      prev = pwm_out;
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_p0();
    test_p3_change();
    test_stop();
    test_inv();
    test_random();
`ifdef PWMDAC_SIGDELTA_EN
    test_sigdelta();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
